// File: rtl/edge_select_pkg.sv
// Shared types and constants for the edge_select output stage.
package edge_select_pkg;

    typedef enum logic [1:0] {
        MAG = 2'd0,
        GX  = 2'd1,
        GY  = 2'd2,
        GXY = 2'd3
    } mode_t;

    localparam int unsigned DEF_WIDTH           = 5;
    localparam int unsigned DEF_FRAME_W         = 318;
    localparam int unsigned DEF_FRAME_H         = 238;
    localparam int unsigned DEF_CONV_THRESH     = 2;
    localparam int unsigned DEF_MAG_THRESH      = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;

    // One extra bit so the absolute value of the most negative gradient fits.
    function automatic int unsigned abs_width(input int unsigned width);
        return width + 1;
    endfunction

    // One-hot button patterns select a gradient mode; anything else is MAG.
    function automatic mode_t decode_mode(input logic [2:0] btn);
        case (btn)
            3'b001:  return GX;
            3'b010:  return GY;
            3'b100:  return GXY;
            default: return MAG;
        endcase
    endfunction

endpackage

// File: rtl/edge_select_debounce.sv
// Per-bit 2-FF synchronizer followed by a stable-sample counter; the level
// output follows the input only after Cycles consecutive differing samples.
module edge_select_debounce #(
    parameter int unsigned Bits   = 3,
    parameter int unsigned Cycles = 250000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [Bits-1:0] raw_i,
    output logic [Bits-1:0] level_o
);

    localparam int unsigned CntW = $clog2(Cycles + 1);

    logic [Bits-1:0] sync1;
    logic [Bits-1:0] sync2;
    logic [CntW-1:0] cnt [Bits];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1   <= '0;
            sync2   <= '0;
            level_o <= '0;
            for (int unsigned i = 0; i < Bits; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_i;
            sync2 <= sync1;
            for (int unsigned i = 0; i < Bits; i++) begin
                if (sync2[i] == level_o[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CntW'(Cycles - 1)) begin
                    level_o[i] <= sync2[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/edge_select.sv
// Thresholds gradient/magnitude beats into one edge bit for the framer.
// Optional EDGE_SELECT_BORDER_EN forces frame-border pixels to 0.
module edge_select
    import edge_select_pkg::*;
#(
    parameter int unsigned Width          = DEF_WIDTH,
    parameter int unsigned MagWidth       = DEF_WIDTH + 1,
    parameter int unsigned FrameW         = DEF_FRAME_W,
    parameter int unsigned FrameH         = DEF_FRAME_H,
    parameter int unsigned ConvThresh     = DEF_CONV_THRESH,
    parameter int unsigned MagThresh      = DEF_MAG_THRESH,
    parameter int unsigned DebounceCycles = DEF_DEBOUNCE_CYCLES
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [3:1]                 button_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic signed [Width-1:0]    gx_i,
    input  logic signed [Width-1:0]    gy_i,
    input  logic [MagWidth-1:0]        mag_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       data_o,
    output logic [1:0]                 mode_o
);

    localparam int unsigned AbsW = abs_width(Width);
    localparam int unsigned XW   = $clog2(FrameW);
    localparam int unsigned YW   = $clog2(FrameH);

    logic [2:0]             btn_level;
    mode_t                  pending_mode;
    mode_t                  mode_q;
    mode_t                  eval_mode;
    logic [XW-1:0]          x_q;
    logic [YW-1:0]          y_q;
    logic                   accept;
    logic                   frame_start;
    logic                   x_last;
    logic                   y_last;
    logic signed [AbsW-1:0] gx_ext;
    logic signed [AbsW-1:0] gy_ext;
    logic [AbsW-1:0]        gx_abs;
    logic [AbsW-1:0]        gy_abs;
    logic                   gx_hit;
    logic                   gy_hit;
    logic                   mag_hit;
    logic                   raw_edge;
    logic                   edge_bit;

    edge_select_debounce #(
        .Bits   (3),
        .Cycles (DebounceCycles)
    ) debounce_inst (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .raw_i   (button_i),
        .level_o (btn_level)
    );

    assign pending_mode = decode_mode(btn_level);

    assign ready_o     = !valid_o || ready_i;
    assign accept      = valid_i && ready_o;
    assign frame_start = (x_q == '0) && (y_q == '0);
    assign x_last      = (x_q == XW'(FrameW - 1));
    assign y_last      = (y_q == YW'(FrameH - 1));

    // The first pixel of a frame is evaluated with the mode it installs.
    assign eval_mode = frame_start ? pending_mode : mode_q;

    assign gx_ext  = AbsW'(gx_i);
    assign gy_ext  = AbsW'(gy_i);
    assign gx_abs  = gx_ext[AbsW-1] ? -gx_ext : gx_ext;
    assign gy_abs  = gy_ext[AbsW-1] ? -gy_ext : gy_ext;
    assign gx_hit  = gx_abs >= AbsW'(ConvThresh);
    assign gy_hit  = gy_abs >= AbsW'(ConvThresh);
    assign mag_hit = mag_i >= MagWidth'(MagThresh);

    always_comb begin
        raw_edge = 1'b0;
        case (eval_mode)
            GX:      raw_edge = gx_hit;
            GY:      raw_edge = gy_hit;
            GXY:     raw_edge = gx_hit || gy_hit;
            default: raw_edge = mag_hit;
        endcase
    end

`ifdef EDGE_SELECT_BORDER_EN
    logic on_border;
    assign on_border = (x_q == '0) || x_last || (y_q == '0) || y_last;
    assign edge_bit  = raw_edge && !on_border;
`else
    assign edge_bit  = raw_edge;
`endif

    // Pixel position of the next accepted beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (accept) begin
            if (x_last) begin
                x_q <= '0;
                y_q <= y_last ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MAG;
        end else if (accept && frame_start) begin
            mode_q <= pending_mode;
        end
    end

    assign mode_o = mode_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= 1'b0;
        end else if (accept) begin
            valid_o <= 1'b1;
            data_o  <= edge_bit;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_select.sv
// Directed table-driven bench for edge_select with a cycle-accurate handshake model.
module tb_edge_select;

    localparam int FW = 10;
    localparam int FH = 6;
    localparam int DB = 1000;

`ifdef EDGE_SELECT_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    typedef struct {
        logic signed [4:0] gx;
        logic signed [4:0] gy;
        logic [5:0]        mag;
        logic              exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [3:1]        button_i;
    logic              valid_i;
    logic              ready_o;
    logic signed [4:0] gx_i;
    logic signed [4:0] gy_i;
    logic [5:0]        mag_i;
    logic              valid_o;
    logic              ready_i;
    logic              data_o;
    logic [1:0]        mode_o;

    int         n_vec  = 0;
    int         n_fail = 0;
    int         mx, my, drained;
    logic       mv, md;
    logic [1:0] mm, pend;

    vec_t tab_a [6];
    vec_t tab_gy[5];
    vec_t tab_b [7];
    vec_t tab_c [5];

    always #5 clk = ~clk;

    edge_select #(
        .Width          (5),
        .MagWidth       (6),
        .FrameW         (FW),
        .FrameH         (FH),
        .ConvThresh     (2),
        .MagThresh      (4),
        .DebounceCycles (DB)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .button_i (button_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .gx_i     (gx_i),
        .gy_i     (gy_i),
        .mag_i    (mag_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .mode_o   (mode_o)
    );

    function automatic vec_t mk(input int gx, input int gy, input int mag, input logic e);
        vec_t v;
        v.gx  = 5'(gx);
        v.gy  = 5'(gy);
        v.mag = 6'(mag);
        v.exp = e;
        return v;
    endfunction

    function automatic logic is_border(input int x, input int y);
        return BORDER && (x == 0 || x == FW - 1 || y == 0 || y == FH - 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at x=%0d y=%0d: got %0d, expected %0d", name, mx, my, act, exp);
        end
    endtask

    // Drive one cycle, compare against the model before the edge, then advance the model.
    task automatic cycle(input logic v, input vec_t t, input logic rdy, output logic acc);
        logic exp_rdy;
        valid_i = v;
        gx_i    = t.gx;
        gy_i    = t.gy;
        mag_i   = t.mag;
        ready_i = rdy;
        #2;
        exp_rdy = !mv || rdy;
        chk("ready_o", int'(ready_o), int'(exp_rdy));
        chk("valid_o", int'(valid_o), int'(mv));
        if (mv) chk("data_o", int'(data_o), int'(md));
        chk("mode_o", int'(mode_o), int'(mm));
        acc = v && exp_rdy;
        @(posedge clk);
        if (mv && rdy) drained++;
        if (acc) begin
            if (mx == 0 && my == 0) mm = pend;
            md = t.exp && !is_border(mx, my);
            mv = 1'b1;
            if (mx == FW - 1) begin
                mx = 0;
                my = (my == FH - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end else if (rdy) begin
            mv = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, mk(0, 0, 0, 1'b0), 1'b1, acc);
    endtask

    task automatic send_tab(input vec_t t[], input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b1, t[i], 1'b1, acc);
    endtask

    task automatic fill_rest(input vec_t t);
        logic acc;
        for (int i = 0; i < FW * FH && !(mx == 0 && my == 0); i++) cycle(1'b1, t, 1'b1, acc);
        chk("frame_wrap", mx + my, 0);
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        mv = 1'b0; md = 1'b0; mm = 2'd0; pend = 2'd0; mx = 0; my = 0;
        chk("reset_data_o", int'(data_o), 0);
    endtask

    initial begin
        logic acc;
        int   accepted;
        vec_t t;
        int   g;

        tab_a[0] = mk(0, 0, 3, 1'b0);
        tab_a[1] = mk(0, 0, 4, 1'b1);
        tab_a[2] = mk(15, 15, 0, 1'b0);
        tab_a[3] = mk(0, 0, 63, 1'b1);
        tab_a[4] = mk(-16, -16, 2, 1'b0);
        tab_a[5] = mk(0, 0, 5, 1'b1);

        tab_gy[0] = mk(0, 15, 0, 1'b1);
        tab_gy[1] = mk(15, 0, 63, 1'b0);
        tab_gy[2] = mk(0, -2, 0, 1'b1);
        tab_gy[3] = mk(0, 1, 0, 1'b0);
        tab_gy[4] = mk(0, -16, 0, 1'b1);

        tab_b[0] = mk(-16, 0, 0, 1'b1);
        tab_b[1] = mk(-2, 0, 0, 1'b1);
        tab_b[2] = mk(1, 0, 0, 1'b0);
        tab_b[3] = mk(2, 0, 0, 1'b1);
        tab_b[4] = mk(-1, 15, 63, 1'b0);
        tab_b[5] = mk(0, -16, 63, 1'b0);
        tab_b[6] = mk(15, 0, 0, 1'b1);

        tab_c[0] = mk(1, 1, 63, 1'b0);
        tab_c[1] = mk(-2, 0, 0, 1'b1);
        tab_c[2] = mk(0, 2, 0, 1'b1);
        tab_c[3] = mk(-1, -1, 63, 1'b0);
        tab_c[4] = mk(-16, 15, 0, 1'b1);

        button_i = 3'b000;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        gx_i = '0; gy_i = '0; mag_i = '0;
        rst_i = 1'b1;
        drained = 0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // Frame 0 in MAG; GY becomes pending mid-frame but must wait for the boundary.
        send_tab(tab_a, 6);
        button_i = 3'b010;
        idle(DB + 10);
        pend = 2'd2;
        fill_rest(mk(0, 15, 0, 1'b0));

        // Frame 1 in GY; GX pending for the next frame.
        send_tab(tab_gy, 5);
        button_i = 3'b001;
        idle(DB + 10);
        pend = 2'd1;
        fill_rest(mk(0, 0, 0, 1'b0));

        // Frame 2 in GX, with a short glitch toward GXY that must be ignored.
        send_tab(tab_b, 7);
        button_i = 3'b100;
        idle(100);
        button_i = 3'b001;
        idle(DB + 100);
        fill_rest(mk(0, 0, 0, 1'b0));

        // Frame 3 in GX with random valid and ready.
        idle(2);
        drained  = 0;
        accepted = 0;
        for (int i = 0; i < 2000 && accepted < FW * FH; i++) begin
            t.gx  = 5'($urandom_range(0, 31));
            t.gy  = 5'($urandom_range(0, 31));
            t.mag = 6'($urandom_range(0, 63));
            g     = int'(t.gx);
            t.exp = ((g < 0) ? -g : g) >= 2;
            cycle($urandom_range(0, 3) != 0, t, 1'($urandom_range(0, 1)), acc);
            if (acc) accepted++;
        end
        chk("rand_accepted", accepted, FW * FH);
        idle(3);
        chk("rand_drained", drained, FW * FH);

        // Frame 4 in GXY, all gradients at maximum.
        button_i = 3'b100;
        idle(DB + 10);
        pend = 2'd3;
        for (int i = 0; i < FW * FH; i++) cycle(1'b1, mk(15, 15, 63, 1'b1), 1'b1, acc);

        // Frame 5 in GXY, then reset mid-frame with an output still pending.
        send_tab(tab_c, 5);
        do_reset();
        idle(DB + 10);
        pend = 2'd3;
        cycle(1'b1, mk(-2, 0, 0, 1'b1), 1'b1, acc);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
